// File: rtl/serial_addsub_if.sv
// Operand/result bundle of the bit-serial adder/subtractor: request side
// (start, sub, a, b) and completion side (busy, done, sum, cout, ovf).
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice and a carry flop walk a
// WIDTH-bit operand pair LSB-first, one bit per clock, behind start/busy/done.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_addsub_if.slave bus
);
    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             bit_s;
    logic             carry_nxt;

    // The single full-adder slice.
    always_comb begin
        bit_s     = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
        carry_nxt = (a_sr_q[0] & b_sr_q[0]) | (b_sr_q[0] & c_q) | (c_q & a_sr_q[0]);
    end

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_RUN: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                res_d  = {bit_s, res_q[WIDTH-1:1]};
                c_d    = carry_nxt;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // c_q is still the carry into the MSB on this last step.
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sum_d   = {bit_s, res_q[WIDTH-1:1]};
                    cout_d  = carry_nxt;
                    ovf_d   = c_q ^ carry_nxt;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (bus.start) begin
                    // Subtraction is a + ~b + 1, the +1 entering through the carry flop.
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.sub ? ~bus.b : bus.b;
                    c_d     = bus.sub;
                    cnt_d   = '0;
                    res_d   = '0;
                end
            end
        endcase
    end

    // NOTE: state is updated with <= only, so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub at WIDTH 8, 16, 2 and 33: directed cases,
// handshake timing, reset abort and a random add/sub regression per width.
module tb_serial_addsub;
    typedef struct {
        int          g;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start_v [4];
    logic        sub_v   [4];
    logic [63:0] a_v     [4];
    logic [63:0] b_v     [4];
    wire         busy_w  [4];
    wire         done_w  [4];
    wire         cout_w  [4];
    wire         ovf_w   [4];
    wire  [63:0] sum_w   [4];

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic int wid(input int g);
        case (g)
            0:       return 8;
            1:       return 16;
            2:       return 2;
            default: return 33;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W = (g == 0) ? 8 : (g == 1) ? 16 : (g == 2) ? 2 : 33;
        serial_addsub_if #(.WIDTH(W)) bus ();
        serial_addsub #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
        assign bus.start = start_v[g];
        assign bus.sub   = sub_v[g];
        assign bus.a     = a_v[g][W-1:0];
        assign bus.b     = b_v[g][W-1:0];
        assign busy_w[g] = bus.busy;
        assign done_w[g] = bus.done;
        assign cout_w[g] = bus.cout;
        assign ovf_w[g]  = bus.ovf;
        assign sum_w[g]  = 64'(bus.sum);
    end

    // Reference: wide arithmetic plus sign-rule overflow.
    function automatic exp_t model(input int g, input logic s, input logic [63:0] a, input logic [63:0] b);
        exp_t        e;
        int          w = wid(g);
        logic [64:0] mask, am, bm, full;
        mask = (65'd1 << w) - 65'd1;
        am   = {1'b0, a} & mask;
        bm   = {1'b0, b} & mask;
        full = s ? am + (~bm & mask) + 65'd1 : am + bm;
        e.g    = g;
        e.sum  = full[63:0] & mask[63:0];
        e.cout = full[w];
        if (s) e.ovf = (am[w-1] != bm[w-1]) && (e.sum[w-1] != am[w-1]);
        else   e.ovf = (am[w-1] == bm[w-1]) && (e.sum[w-1] != am[w-1]);
        return e;
    endfunction

    // Drives one start pulse; returns in the first cycle after the capture edge.
    task automatic issue(input int g, input logic s, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        start_v[g] = 1'b1;
        sub_v[g]   = s;
        a_v[g]     = a;
        b_v[g]     = b;
        exp_q.push_back(model(g, s, a, b));
        @(negedge clk);
        start_v[g] = 1'b0;
        sub_v[g]   = 1'($urandom_range(0, 1));
        a_v[g]     = {$urandom, $urandom};
        b_v[g]     = {$urandom, $urandom};
    endtask

    // Waits (bounded) for done, then pops the scoreboard and compares the result.
    task automatic collect(input int g, input string name, input int cyc0,
                           output int cyc, output int bcnt);
        logic [63:0] held = sum_w[g];
        bit          leak = 1'b0;
        exp_t        e;
        cyc  = cyc0;
        bcnt = 0;
        while (done_w[g] !== 1'b1 && cyc < 200) begin
            if (busy_w[g] === 1'b1) bcnt++;
            if (sum_w[g] !== held) leak = 1'b1;
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (cyc >= 200) begin
            n_fail++;
            $display("FAIL %s timeout: no done within %0d cycles", name, cyc);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        e = exp_q.pop_front();
        if (leak || busy_w[g] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s handshake: sum_changed_early=%0d busy_at_done=%b want 0/0", name, leak, busy_w[g]);
        end
        n_tests++;
        if (sum_w[g] !== e.sum || cout_w[g] !== e.cout || ovf_w[g] !== e.ovf) begin
            n_fail++;
            $display("FAIL %s result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     name, sum_w[g], cout_w[g], ovf_w[g], e.sum, e.cout, e.ovf);
        end
    endtask

    task automatic check_zero(input int g, input string name);
        n_tests++;
        if (sum_w[g] !== 64'd0 || {busy_w[g], done_w[g], cout_w[g], ovf_w[g]} !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     name, busy_w[g], done_w[g], sum_w[g], cout_w[g], ovf_w[g]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int g = 0; g < 4; g++) begin
            start_v[g] = 1'b0; sub_v[g] = 1'b0; a_v[g] = '0; b_v[g] = '0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 4; g++) check_zero(g, $sformatf("reset_w%0d", wid(g)));
    endtask

    task automatic test_add();
        int cyc, bc;
        issue(0, 1'b0, 64'h3C, 64'h0F);
        collect(0, "add_3c_0f", 1, cyc, bc);
        n_tests++;
        if (cyc !== 9) begin n_fail++; $display("FAIL add_latency: got %0d want 9", cyc); end
        n_tests++;
        if (bc !== 8) begin n_fail++; $display("FAIL add_busy_cycles: got %0d want 8", bc); end
        issue(0, 1'b0, 64'hFF, 64'h01);
        collect(0, "add_ff_01", 1, cyc, bc);
        issue(0, 1'b0, 64'h7F, 64'h01);
        collect(0, "add_7f_01", 1, cyc, bc);
    endtask

    task automatic test_sub();
        int cyc, bc;
        issue(0, 1'b1, 64'h05, 64'h07);
        collect(0, "sub_05_07", 1, cyc, bc);
        issue(0, 1'b1, 64'h80, 64'h01);
        collect(0, "sub_80_01", 1, cyc, bc);
    endtask

    task automatic test_start_in_run();
        int cyc, bc;
        issue(0, 1'b0, 64'h12, 64'h34);
        repeat (2) @(negedge clk);
        start_v[0] = 1'b1; sub_v[0] = 1'b1; a_v[0] = 64'hFF; b_v[0] = 64'h01;
        @(negedge clk);
        start_v[0] = 1'b0;
        collect(0, "start_in_run", 4, cyc, bc);
        @(negedge clk);
        n_tests++;
        if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_run_idle: got busy=%b done=%b want 0/0", busy_w[0], done_w[0]);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        @(negedge clk);
        start_v[0] = 1'b1; sub_v[0] = 1'b0; a_v[0] = 64'hA5; b_v[0] = 64'h3C;
        exp_q.push_back(model(0, 1'b0, 64'hA5, 64'h3C));
        @(negedge clk);
        sub_v[0] = 1'b1; a_v[0] = 64'h10; b_v[0] = 64'h20;
        exp_q.push_back(model(0, 1'b1, 64'h10, 64'h20));
        collect(0, "b2b_first", 1, cyc, bc);
        n_tests++;
        if (cyc !== 9) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 9", cyc); end
        @(negedge clk);
        start_v[0] = 1'b0;
        n_tests++;
        if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_no_idle_gap: got busy=%b done=%b want 1/0", busy_w[0], done_w[0]);
        end
        collect(0, "b2b_second", 1, cyc, bc);
        n_tests++;
        if (cyc !== 9) begin n_fail++; $display("FAIL b2b_done_spacing: got %0d want 9", cyc); end
    endtask

    task automatic test_reset_abort();
        int cyc, bc;
        bit saw_done = 1'b0;
        issue(0, 1'b0, 64'h3C, 64'h0F);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        void'(exp_q.pop_back());
        check_zero(0, "abort_outputs");
        repeat (20) begin
            @(negedge clk);
            if (done_w[0] === 1'b1) saw_done = 1'b1;
        end
        n_tests++;
        if (saw_done) begin n_fail++; $display("FAIL abort_no_done: got done=1 want none"); end
        issue(0, 1'b0, 64'h01, 64'h01);
        collect(0, "after_abort_01_01", 1, cyc, bc);
    endtask

    task automatic test_wide();
        int cyc, bc;
        issue(1, 1'b0, 64'hFFFF, 64'h0001);
        collect(1, "w16_ffff_0001", 1, cyc, bc);
        n_tests++;
        if (cyc !== 17) begin n_fail++; $display("FAIL w16_latency: got %0d want 17", cyc); end
    endtask

    function automatic logic [63:0] pick(input int g);
        int w = wid(g);
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return ~64'd0;
            2:       return 64'd1 << (w - 1);
            3:       return (64'd1 << (w - 1)) - 64'd1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic test_random();
        int cyc, bc;
        for (int g = 0; g < 4; g++) begin
            for (int i = 0; i < 200; i++) begin
                issue(g, 1'($urandom_range(0, 1)), pick(g), pick(g));
                collect(g, $sformatf("rand_w%0d_%0d", wid(g), i), 1, cyc, bc);
                if (i == 0) begin
                    n_tests++;
                    if (cyc !== wid(g) + 1 || bc !== wid(g)) begin
                        n_fail++;
                        $display("FAIL rand_w%0d_timing: got latency=%0d busy=%0d want %0d/%0d",
                                 wid(g), cyc, bc, wid(g) + 1, wid(g));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_start_in_run();
        test_back_to_back();
        test_reset_abort();
        test_wide();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
